// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and default widths for the result RAM arbiter
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_FORCE
  } arb_state_t;

  typedef enum logic {
    WRITER,
    READER
  } owner_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// rtl/rd_valid_pipe.sv - LAT-deep read-grant flag pipeline with data capture for RAM clients
module rd_valid_pipe #(
  parameter int LAT    = 1,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LAT-1:0]    flag_q;
  logic [DATA_W-1:0] data_q;
  logic              capture;

  // dout_i is sampled on the edge that moves the flag into the last stage
  generate
    if (LAT == 1) begin : g_lat1
      assign capture = gnt_i;
    end else begin : g_latn
      assign capture = flag_q[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
      data_q <= '0;
    end else begin
      flag_q[0] <= gnt_i;
      for (int i = 1; i < LAT; i++) begin
        flag_q[i] <= flag_q[i-1];
      end
      if (capture) begin
        data_q <= dout_i;
      end
    end
  end

  assign valid_o = flag_q[LAT-1];
  assign data_o  = data_q;

endmodule

// File: rtl/result_ram_arbiter.sv
// rtl/result_ram_arbiter.sv - round-robin writer/reader arbiter for the 16x18 result RAM
// Optional ARB_STATS_EN adds saturating conflict and forced-read counters.
module result_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic              wr_lock,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ram_en,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced
`endif
);

  localparam int WAIT_W = 4;

  arb_state_t        state_q, state_d;
  owner_t            last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= READER;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wait_d  = wait_q;
    if (wr_gnt) begin
      last_d = WRITER;
    end else if (rd_gnt) begin
      last_d = READER;
    end
    // The reader's wait counts from the first cycle the writer holds the lock
    if (rd_gnt || !rd_req) begin
      wait_d = '0;
    end else if (state_q == WR_BURST || (wr_gnt && wr_lock)) begin
      wait_d = wait_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (wr_gnt && wr_lock) state_d = WR_BURST;
      end
      WR_BURST: begin
        if (!wr_req || !wr_lock) begin
          state_d = IDLE;
        end else if (wait_d == WAIT_W'(MAX_WAIT)) begin
          state_d = RD_FORCE;
        end
      end
      RD_FORCE: begin
        state_d = wr_lock ? WR_BURST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (wr_req && rd_req) begin
            wr_gnt = (last_q == READER);
            rd_gnt = (last_q == WRITER);
          end else begin
            wr_gnt = wr_req;
            rd_gnt = rd_req;
          end
        end
        WR_BURST: wr_gnt = wr_req;
        RD_FORCE: rd_gnt = rd_req;
        default: ;
      endcase
    end
    ram_en   = wr_gnt | rd_gnt;
    ram_web  = wr_gnt;
    ram_addr = '0;
    ram_din  = '0;
    if (wr_gnt) begin
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end else if (rd_gnt) begin
      ram_addr = rd_addr;
    end
  end

  rd_valid_pipe #(
    .LAT    (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (reset_n),
    .gnt_i   (rd_gnt),
    .dout_i  (ram_dout),
    .valid_o (rd_valid),
    .data_o  (rd_data)
  );

`ifdef ARB_STATS_EN
  logic [15:0] conf_q, forced_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conf_q   <= '0;
      forced_q <= '0;
    end else begin
      if (wr_req && rd_req && conf_q != 16'hFFFF) begin
        conf_q <= conf_q + 1'b1;
      end
      if (state_d == RD_FORCE && state_q != RD_FORCE && forced_q != 16'hFFFF) begin
        forced_q <= forced_q + 1'b1;
      end
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_forced    = forced_q;
`endif

endmodule

// File: tb/tb_result_ram_arbiter.sv
// tb/tb_result_ram_arbiter.sv - self-checking bench for result_ram_arbiter
module tb_result_ram_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 18;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_req = 1'b0, wr_lock = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, rd_gnt, rd_valid, ram_en, ram_web;
  logic [DW-1:0] rd_data, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_conflicts, stat_forced;
`endif

  int errors = 0;
  int checks = 0;

  result_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_en(ram_en), .ram_web(ram_web), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
`endif
  );

  always #5 clk = ~clk;

  // RAM macro model: asynchronous read, write on the rising edge
  logic [DW-1:0] mem [16];
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_en && ram_web) mem[ram_addr] <= ram_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: abstract arbitration rules plus a queue of promised read returns
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] exp_rdata;
  bit            m_burst, m_force, m_last_wr;
  int            m_wait, m_conf, m_forced, cyc = 0;

  always @(negedge clk) begin
    bit eg, er, ev;
    int new_wait;
    if (!reset_n) begin
      m_burst = 0; m_force = 0; m_last_wr = 0; m_wait = 0;
      m_conf = 0; m_forced = 0; exp_rdata = '0;
      pend.delete();
      check("rst_grants", {30'd0, wr_gnt, rd_gnt}, 32'd0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
    end else begin
      if (m_force) begin eg = 0; er = rd_req; end
      else if (m_burst) begin eg = wr_req; er = 0; end
      else if (wr_req && rd_req) begin eg = !m_last_wr; er = m_last_wr; end
      else begin eg = wr_req; er = rd_req; end
      check("m_wr_gnt", wr_gnt, eg);
      check("m_rd_gnt", rd_gnt, er);
      check("m_ram_en", ram_en, eg | er);
      check("m_ram_web", ram_web, eg);
      check("m_ram_addr", ram_addr, eg ? wr_addr : (er ? rd_addr : '0));
      check("m_ram_din", ram_din, eg ? wr_data : '0);
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      if (ev) begin exp_rdata = pend[0].data; void'(pend.pop_front()); end
      check("m_rd_valid", rd_valid, ev);
      check("m_rd_data", rd_data, exp_rdata);
`ifdef ARB_STATS_EN
      check("m_stat_conflicts", stat_conflicts, m_conf);
      check("m_stat_forced", stat_forced, m_forced);
`endif
      if (wr_req && rd_req) m_conf++;
      new_wait = (er || !rd_req) ? 0 : (((m_burst && !m_force) || (eg && wr_lock)) ? m_wait + 1 : m_wait);
      if (m_force) begin
        m_force = 0; m_burst = wr_lock;
      end else if (m_burst) begin
        if (!wr_req || !wr_lock) m_burst = 0;
        else if (new_wait == MAX_WAIT) begin m_force = 1; m_forced++; end
      end else if (eg && wr_lock) begin
        m_burst = 1;
      end
      m_wait = new_wait;
      if (eg) m_last_wr = 1; else if (er) m_last_wr = 0;
      if (er) pend.push_back('{cyc + RD_LAT, exp_mem[rd_addr]});
      if (eg) exp_mem[wr_addr] = wr_data;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int nw, acc, wb;
    bit got, g_w, g_r;
    for (int i = 0; i < 16; i++) begin
      mem[i] = DW'(18'h101 * i);
      exp_mem[i] = DW'(18'h101 * i);
    end
    // Requests pending during reset must not be granted
    wr_req = 1; rd_req = 1; wr_addr = 7; wr_data = 18'h15555; rd_addr = 3;
    @(negedge clk);
    check("rst_no_wr_gnt", wr_gnt, 0);
    check("rst_no_rd_gnt", rd_gnt, 0);
    tick(); tick();
    reset_n = 1;
    @(negedge clk);
    check("tie_c1_wr", wr_gnt, 1);
    check("tie_c1_rd", rd_gnt, 0);
    tick(); wr_req = 0;
    @(negedge clk);
    check("tie_c2_rd", rd_gnt, 1);
    tick(); rd_req = 0;
    @(negedge clk);
    check("tie_rd_valid", rd_valid, 1);
    check("tie_rd_data", rd_data, 18'h00303);

    tick(); wr_req = 1; wr_addr = 3; wr_data = 18'h2ABCD; wr_lock = 0;
    @(negedge clk);
    check("solo_wr_gnt", wr_gnt, 1);
    check("solo_ram_web", ram_web, 1);
    check("solo_ram_addr", ram_addr, 3);
    check("solo_ram_din", ram_din, 18'h2ABCD);

    tick(); wr_addr = 5; wr_data = 18'h00011;
    @(negedge clk);
    check("raw_wr_gnt", wr_gnt, 1);
    tick(); wr_req = 0; rd_req = 1; rd_addr = 5;
    @(negedge clk);
    check("raw_rd_gnt", rd_gnt, 1);
    tick(); rd_req = 0;
    @(negedge clk);
    check("raw_rd_valid", rd_valid, 1);
    check("raw_rd_data", rd_data, 18'h00011);

    // Locked burst of 16 writes with a reader waiting from the first cycle
    tick(); wr_req = 1; wr_lock = 1; wr_addr = 0; wr_data = 18'h3F000; rd_req = 1; rd_addr = 3;
    nw = 0; acc = 0; wb = -1; got = 0;
    for (int k = 0; k < 40 && !(nw == 16 && got); k++) begin
      @(negedge clk);
      g_w = wr_gnt; g_r = rd_gnt;
      if (g_w || g_r) acc++;
      if (rd_valid) begin check("burst_rd_data", rd_data, 18'h3F003); got = 1; end
      if (g_r) wb = nw;
      if (g_w) nw++;
      tick();
      if (g_r) rd_req = 0;
      if (g_w) begin
        if (nw == 16) begin wr_req = 0; wr_lock = 0; end
        else begin wr_addr = AW'(nw); wr_data = 18'h3F000 + DW'(nw); end
      end
    end
    check("burst_complete", {31'd0, nw == 16 && got}, 1);
    check("burst_writes_before_force", wb, 8);
    check("burst_access_cycles", acc, 17);

    tick(); rd_req = 1; rd_addr = 1;
    @(negedge clk);
    check("mr_rd_gnt", rd_gnt, 1);
    tick(); rd_req = 0; reset_n = 0;
    @(negedge clk);
    check("mr_no_rd_valid", rd_valid, 0);
    check("mr_rd_data", rd_data, 0);
    tick(); reset_n = 1; wr_req = 1; wr_lock = 1; wr_addr = 9; wr_data = 18'h0ABCD;
    @(negedge clk);
    check("lk_wr_gnt", wr_gnt, 1);
    // Reset while the burst lock is held, then a tie must go to the writer
    tick(); wr_req = 0; wr_lock = 0; reset_n = 0;
    @(negedge clk);
    check("lk_rst_ram_en", ram_en, 0);
    tick(); reset_n = 1; wr_req = 1; wr_addr = 10; wr_data = 18'h00001; rd_req = 1; rd_addr = 9;
    @(negedge clk);
    check("post_rst_tie_wr", wr_gnt, 1);
    tick(); wr_req = 0;
    @(negedge clk);
    check("post_rst_rd_gnt", rd_gnt, 1);
    tick(); rd_req = 0;
    @(negedge clk);
    check("post_rst_rd_data", rd_data, 18'h0ABCD);
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
